// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// an ALU writeback requester (A) and a load writeback requester (B).
// Each requester owns a one-entry holding register. The block also exports
// a mask of registers that still have a write in flight.
// Optional feature macro: REGFILE_WB_RR_EN selects round-robin arbitration
// for contended writes to different registers. Without it, A has fixed priority.
module regfile_wb_arbiter #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [REG_ADDR_W-1:0]        a_reg,
  input  logic [DATA_W-1:0]            a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [REG_ADDR_W-1:0]        b_reg,
  input  logic [DATA_W-1:0]            b_data,
  output logic                         regWrite,
  output logic [REG_ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]            writeData,
  output logic [(1<<REG_ADDR_W)-1:0]   pending
);
  localparam int NREG = 1 << REG_ADDR_W;

  // Holding entries
  logic                  a_full_q, b_full_q;
  logic                  a_age_q, b_age_q;
  logic [REG_ADDR_W-1:0] a_reg_q, b_reg_q;
  logic [DATA_W-1:0]     a_data_q, b_data_q;

  // Registered write port
  logic                  regWrite_q;
  logic [REG_ADDR_W-1:0] writeReg_q;
  logic [DATA_W-1:0]     writeData_q;

  logic                  grant_a, grant_b, same_dst;
  logic                  a_acc, b_acc;
  logic                  regWrite_d;
  logic [REG_ADDR_W-1:0] writeReg_d;
  logic [DATA_W-1:0]     writeData_d;

`ifdef REGFILE_WB_RR_EN
  // Pointer: 0 means A has priority for the next contended grant
  logic rr_q;
  logic contended;
  assign contended = a_full_q & b_full_q & ~same_dst;
`endif

  assign same_dst = (a_reg_q == b_reg_q);

  // Pick at most one entry to drain this cycle
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full_q && !b_full_q) begin
      grant_a = 1'b1;
    end else if (!a_full_q && b_full_q) begin
      grant_b = 1'b1;
    end else if (a_full_q && b_full_q) begin
      if (same_dst) begin
        // Older capture writes first; a same-edge tie lets A go first
        if (b_age_q && !a_age_q) grant_b = 1'b1;
        else                     grant_a = 1'b1;
      end else begin
`ifdef REGFILE_WB_RR_EN
        if (rr_q) grant_b = 1'b1;
        else      grant_a = 1'b1;
`else
        grant_a = 1'b1;
`endif
      end
    end
  end

  // Ready depends on state only, so a draining entry can refill the same edge
  assign a_ready = ~a_full_q | grant_a;
  assign b_ready = ~b_full_q | grant_b;
  assign a_acc   = a_valid & a_ready;
  assign b_acc   = b_valid & b_ready;

  // Next write-port contents; register 0 consumes its slot without a write
  always_comb begin
    writeReg_d  = grant_b ? b_reg_q  : a_reg_q;
    writeData_d = grant_b ? b_data_q : a_data_q;
    regWrite_d  = (grant_a | grant_b) && (writeReg_d != '0);
  end

  // Entry, age and write-port state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_full_q    <= 1'b0;
      b_full_q    <= 1'b0;
      a_age_q     <= 1'b0;
      b_age_q     <= 1'b0;
      a_reg_q     <= '0;
      b_reg_q     <= '0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      if (a_acc) begin
        a_full_q <= 1'b1;
        a_reg_q  <= a_reg;
        a_data_q <= a_data;
      end else if (grant_a) begin
        a_full_q <= 1'b0;
      end
      if (b_acc) begin
        b_full_q <= 1'b1;
        b_reg_q  <= b_reg;
        b_data_q <= b_data;
      end else if (grant_b) begin
        b_full_q <= 1'b0;
      end
      // A fresh capture is young; a surviving entry beside it becomes old
      if (a_acc)                                a_age_q <= 1'b0;
      else if (b_acc && a_full_q && !grant_a)   a_age_q <= 1'b1;
      else if (grant_a)                         a_age_q <= 1'b0;
      if (b_acc)                                b_age_q <= 1'b0;
      else if (a_acc && b_full_q && !grant_b)   b_age_q <= 1'b1;
      else if (grant_b)                         b_age_q <= 1'b0;

      regWrite_q <= regWrite_d;
      if (regWrite_d) begin
        writeReg_q  <= writeReg_d;
        writeData_q <= writeData_d;
      end
    end
  end

`ifdef REGFILE_WB_RR_EN
  // Hand priority to the loser after each contended grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rr_q <= 1'b0;
    else if (contended) rr_q <= grant_a;
  end
`endif

  assign regWrite  = regWrite_q;
  assign writeReg  = writeReg_q;
  assign writeData = writeData_q;

  // Pending mask straight from entry state; register 0 is never pending
  assign pending[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_pend
      assign pending[gi] = (a_full_q && (a_reg_q == REG_ADDR_W'(gi))) |
                           (b_full_q && (b_reg_q == REG_ADDR_W'(gi)));
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed literal checks followed by
// randomized traffic compared every cycle against a capture-order model.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_reg = '0, b_reg = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [NR-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  regfile_wb_arbiter #(.REG_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each requester holds one entry tagged with its capture sequence number
  bit            m_full [2] = '{1'b0, 1'b0};
  logic [AW-1:0] m_reg  [2] = '{'0, '0};
  logic [DW-1:0] m_data [2] = '{'0, '0};
  int            m_stamp[2] = '{0, 0};
  int            m_seq = 0;
  bit            m_rr  = 1'b0;    // 1 = B preferred next contended different-dest pick
  bit            m_rw  = 1'b0;
  logic [AW-1:0] m_wr  = '0;
  logic [DW-1:0] m_wd  = '0;
  bit            m_acc_a = 1'b0, m_acc_b = 1'b0;

  // 0 none, 1 A, 2 B
  function automatic int m_grant();
    if (m_full[0] && !m_full[1]) return 1;
    if (!m_full[0] && m_full[1]) return 2;
    if (!m_full[0]) return 0;
    if (m_reg[0] == m_reg[1]) return (m_stamp[1] < m_stamp[0]) ? 2 : 1;
`ifdef REGFILE_WB_RR_EN
    return m_rr ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_full = '{1'b0, 1'b0};
      m_rr = 1'b0; m_rw = 1'b0; m_wr = '0; m_wd = '0;
      m_acc_a = 1'b0; m_acc_b = 1'b0;
    end else begin
      int  g;
      bit  contended;
      g = m_grant();
      contended = m_full[0] && m_full[1] && (m_reg[0] != m_reg[1]);
      m_acc_a = a_valid && (!m_full[0] || g == 1);
      m_acc_b = b_valid && (!m_full[1] || g == 2);
      m_rw = 1'b0;
      if (g != 0) begin
        if (m_reg[g-1] != 0) begin
          m_rw = 1'b1;
          m_wr = m_reg[g-1];
          m_wd = m_data[g-1];
        end
        m_full[g-1] = 1'b0;
        if (contended) m_rr = (g == 1);
      end
      m_seq++;
      if (m_acc_a) begin m_full[0] = 1'b1; m_reg[0] = a_reg; m_data[0] = a_data; m_stamp[0] = m_seq; end
      if (m_acc_b) begin m_full[1] = 1'b1; m_reg[1] = b_reg; m_data[1] = b_data; m_stamp[1] = m_seq; end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en && rst) begin
      logic [NR-1:0] ep;
      int g;
      ep = '0;
      for (int i = 1; i < NR; i++)
        ep[i] = (m_full[0] && m_reg[0] == i) || (m_full[1] && m_reg[1] == i);
      g = m_grant();
      chk("cyc_a_ready", a_ready, (!m_full[0] || g == 1));
      chk("cyc_b_ready", b_ready, (!m_full[1] || g == 2));
      chk("cyc_pending", pending, ep);
      chk("cyc_regWrite", regWrite, m_rw);
      if (m_rw) begin
        chk("cyc_writeReg", writeReg, m_wr);
        chk("cyc_writeData", writeData, m_wd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit v, input int r, input logic [DW-1:0] d);
    a_valid = v; a_reg = AW'(r); a_data = d;
    if (v) $display("txn A reg=%0d data=%0h", r, d);
  endtask

  task automatic drive_b(input bit v, input int r, input logic [DW-1:0] d);
    b_valid = v; b_reg = AW'(r); b_data = d;
    if (v) $display("txn B reg=%0d data=%0h", r, d);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", regWrite, 0);
    chk("rst_writeReg", writeReg, 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b1;
    #1;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    cmp_en = 1'b1;
    step();

    // Single write: A reg1 = 68
    drive_a(1, 1, 68);
    step();
    drive_a(0, 0, 0);
    chk("single_pending", pending, 32'h2);
    chk("single_noWrite", regWrite, 0);
    step();
    chk("single_regWrite", regWrite, 1);
    chk("single_writeReg", writeReg, 1);
    chk("single_writeData", writeData, 68);
    chk("single_pend_clr", pending, 0);
    step();
    chk("single_one_cycle", regWrite, 0);

    // Back-to-back from A
    drive_a(1, 1, 68);
    step();
    chk("b2b_a_ready", a_ready, 1);
    drive_a(1, 2, 82);
    step();
    drive_a(0, 0, 0);
    chk("b2b_w1_reg", writeReg, 1);
    chk("b2b_w1_data", writeData, 68);
    step();
    chk("b2b_w2_en", regWrite, 1);
    chk("b2b_w2_reg", writeReg, 2);
    chk("b2b_w2_data", writeData, 82);
    step();

    // Simultaneous, different destinations
    drive_a(1, 3, 5);
    drive_b(1, 4, 9);
    step();
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    chk("diff_pending", pending, 32'h18);
    step();
    chk("diff_first_reg", writeReg, 3);
    chk("diff_first_data", writeData, 5);
    step();
    chk("diff_second_reg", writeReg, 4);
    chk("diff_second_data", writeData, 9);
    step();

    // Simultaneous, same destination: A's value first, B's lands last
    drive_a(1, 7, 1);
    drive_b(1, 7, 2);
    step();
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    step();
    chk("same_first_data", writeData, 1);
    step();
    chk("same_last_en", regWrite, 1);
    chk("same_last_data", writeData, 2);
    step();

    // B captured one cycle before A, both to reg 7
    drive_b(1, 7, 33);
    step();
    drive_b(0, 0, 0);
    drive_a(1, 7, 44);
    step();
    drive_a(0, 0, 0);
    chk("order_first_data", writeData, 33);
    step();
    chk("order_second_data", writeData, 44);
    step();

    // Register 0 write is consumed silently
    drive_a(1, 0, 32'hFFFF_FFFF);
    chk("r0_a_ready", a_ready, 1);
    step();
    drive_a(0, 0, 0);
    chk("r0_pending", pending, 0);
    step();
    chk("r0_noWrite", regWrite, 0);
    step();

    // Reset while both entries full
    drive_a(1, 5, 55);
    drive_b(1, 6, 66);
    step();
    drive_a(1, 8, 88);
    drive_b(1, 9, 99);
    step();
    chk("midrst_pre_write", regWrite, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_regWrite", regWrite, 0);
    chk("midrst_pending", pending, 0);
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    step();
    #2;
    rst = 1'b1;
    repeat (3) begin
      step();
      chk("midrst_no_write", regWrite, 0);
    end

    // Randomized traffic, small register range to force collisions
    for (int c = 0; c < 3000; c++) begin
      if (!a_valid || m_acc_a) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_reg   = AW'($urandom_range(0, 7));
        a_data  = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        a_valid = 1'b0;
      end
      if (!b_valid || m_acc_b) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_reg   = AW'($urandom_range(0, 7));
        b_data  = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        b_valid = 1'b0;
      end
      step();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
